// File: rtl/weight_loader_if.sv
// Weight stream handshake between the upstream weight source and the column loader.
interface weight_loader_if #(
  parameter int DW = 8
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/weight_loader.sv
// Column weight loader: takes ROWS signed weights from a valid/ready stream
// and shifts them down a chain of PEs through a shared enable. The first word
// accepted ends up in the bottom row, the last one in row 0.
module weight_loader #(
  parameter int ROWS = 8,
  parameter int DW   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  weight_loader_if.slave s,
  output logic           pe_wen,
  output logic [DW-1:0]  pe_win,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          pe_wen_q, pe_wen_d;
  logic [DW-1:0] pe_win_q, pe_win_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          s_ready_s;
  logic          accept_s;

  // Ready only while collecting words; count never exceeds ROWS in LOAD.
  assign s_ready_s = (state_q == LOAD) && (count_q < CW'(ROWS));
  assign accept_s  = s.s_valid && s_ready_s;
  assign s.s_ready = s_ready_s;

  // Next-state and next-output decode; outputs are registered so every
  // accepted word reaches the column exactly one cycle after acceptance.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pe_wen_d = 1'b0;
    pe_win_d = pe_win_q;
    case (state_q)
      IDLE: begin
        // start together with abort is treated as no request at all
        if (start && !abort) begin
          state_d = LOAD;
          count_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // an accept in the abort cycle is dropped, not forwarded
        if (abort) begin
          state_d = IDLE;
        end else if (accept_s) begin
          count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
          pe_wen_d = 1'b1;
          pe_win_d = s.s_data;
          if (count_q == CW'(ROWS - 1)) begin
            state_d = FLUSH;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FLUSH: begin
        // final shift pulse is on the outputs during this cycle
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      pe_wen_q <= 1'b0;
      pe_win_q <= {DW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pe_wen_q <= pe_wen_d;
      pe_win_q <= pe_win_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pe_wen = pe_wen_q;
  assign pe_win = pe_win_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: expected shift words are queued when
// stimulus is driven and popped when pe_wen pulses; an 8-PE chain model
// checks final column contents.
module tb_weight_loader;
  localparam int ROWS = 8;
  localparam int DW   = 8;

  typedef struct {
    logic [DW-1:0] word;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pe_wen;
  logic [DW-1:0] pe_win;
  logic          busy;
  logic          done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  exp_t sb[$];
  exp_t e;
  logic [DW-1:0] chain[ROWS];
  logic [DW-1:0] w_desc[ROWS];
  logic [DW-1:0] w_ext[ROWS];

  weight_loader_if #(.DW(DW)) sif ();

  weight_loader #(.ROWS(ROWS), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .s       (sif.slave),
    .pe_wen  (pe_wen),
    .pe_win  (pe_win),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // cycle k is the interval following the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pop scoreboard on every shift pulse, shift chain model, log done
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pe_wen === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pe_wen_unexpected cyc=%0d got pe_win=%h expected no pulse", cyc, pe_win);
      end else begin
        e = sb.pop_front();
        if (pe_win !== e.word || cyc !== e.cyc) begin
          errors++;
          $display("FAIL pe_win cyc=%0d got %h, expected %h at cyc %0d", cyc, pe_win, e.word, e.cyc);
        end
      end
      for (int i = ROWS - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = pe_win;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_chain();
    for (int i = 0; i < ROWS; i++) chain[i] = 8'hEE;
  endtask

  // Drive start in the current cycle, then stream w (first word -> bottom row)
  // skipping valid on relative cycles gap1/gap2 and pulsing start at start_at.
  // Returns in the cycle after the last accept with junk still offered.
  task automatic feed(input logic [DW-1:0] w[ROWS], input int gap1, input int gap2,
                      input int start_at);
    int idx = 0;
    int rel = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (idx < ROWS) begin
      start = (rel == start_at);
      if (rel == gap1 || rel == gap2) begin
        sif.s_valid = 1'b0;
      end else begin
        sif.s_valid = 1'b1;
        sif.s_data  = w[idx];
        sb.push_back('{w[idx], cyc + 1});
        idx++;
      end
      tick();
      rel++;
    end
    start = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hA5;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({pe_wen, busy, done, sif.s_ready} !== 4'b0000 || pe_win !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got wen/busy/done/rdy=%b%b%b%b win=%h, expected 0000 00",
               pe_wen, busy, done, sif.s_ready, pe_win);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    checks++;
    if (sif.s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b, expected 0 0", sif.s_ready, busy);
    end
  endtask

  task automatic test_basic(input int gap1, input int gap2, input int lat, input string name);
    int c0 = cyc;
    int d0 = done_cnt;
    int n = 0;
    clear_chain();
    feed(w_desc, gap1, gap2, -1);
    checks++;
    if (busy !== 1'b1 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_flush got busy=%b rdy=%b, expected 1 0", name, busy, sif.s_ready);
    end
    while (done_cnt == d0 && n < 30) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (done_cyc !== c0 + lat || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL %s_done got cyc %0d count %0d, expected cyc %0d count %0d",
               name, done_cyc - c0, done_cnt - d0, lat, 1);
    end
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (chain[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL %s_chain row%0d got %h, expected %h", name, i, chain[i], 8'(i + 1));
      end
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d busy=%b, expected 0 0", name, sb.size(), busy);
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = w_desc[k];
      sb.push_back('{w_desc[k], cyc + 1});
      tick();
    end
    sif.s_data = w_desc[3];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b rdy=%b, expected 0 0", busy, sif.s_ready);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt !== d0 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_no_done got done %0d pending %0d, expected 0 0", done_cnt - d0, sb.size());
    end
    test_basic(-1, -1, ROWS + 2, "after_abort");
  endtask

  task automatic test_abort_flush();
    int d0 = done_cnt;
    feed(w_ext, -1, -1, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_flush got done %0d busy %b pending %0d, expected 0 0 0",
               done_cnt - d0, busy, sb.size());
    end
  endtask

  task automatic test_idle_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle got busy=%b rdy=%b, expected 0 0", busy, sif.s_ready);
    end
    repeat (2) tick();
  endtask

  task automatic test_start_ignored();
    int c0 = cyc;
    int d0 = done_cnt;
    clear_chain();
    feed(w_desc, -1, -1, 4);
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) tick();
    checks++;
    if (done_cnt !== d0 + 1 || done_cyc !== c0 + ROWS + 2 || sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got done %0d at %0d pending %0d busy %b, expected 1 at %0d 0 0",
               done_cnt - d0, done_cyc - c0, sb.size(), busy, ROWS + 2);
    end
  endtask

  task automatic test_extremes();
    int d0 = done_cnt;
    int n = 0;
    clear_chain();
    feed(w_ext, -1, -1, -1);
    while (done_cnt == d0 && n < 30) begin tick(); n++; end
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (chain[ROWS-1-i] !== w_ext[i]) begin
        errors++;
        $display("FAIL extremes_row%0d got %h, expected %h", ROWS - 1 - i, chain[ROWS-1-i], w_ext[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    // the word accepted in cycle 4 would pulse in cycle 5, killed by reset first
    for (int k = 0; k < 4; k++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = w_desc[k];
      if (k < 3) sb.push_back('{w_desc[k], cyc + 1});
      tick();
    end
    sif.s_data = w_desc[4];
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pe_wen, busy, done, sif.s_ready} !== 4'b0000 || pe_win !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got wen/busy/done/rdy=%b%b%b%b win=%h, expected 0000 00",
               pe_wen, busy, done, sif.s_ready, pe_win);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (sif.s_ready !== 1'b0 || busy !== 1'b0 || done_cnt !== d0 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_idle got rdy=%b busy=%b done %0d pending %0d, expected 0 0 0 0",
               sif.s_ready, busy, done_cnt - d0, sb.size());
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    for (int i = 0; i < ROWS; i++) w_desc[i] = 8'(ROWS - i);
    w_ext[0] = 8'h80; w_ext[1] = 8'h7F; w_ext[2] = 8'h00; w_ext[3] = 8'h01;
    w_ext[4] = 8'hFF; w_ext[5] = 8'h55; w_ext[6] = 8'hAA; w_ext[7] = 8'h40;
    clear_chain();
    test_reset();
    test_basic(-1, -1, ROWS + 2, "basic");
    test_basic(3, 6, ROWS + 4, "gaps");
    test_abort();
    test_abort_flush();
    test_idle_abort();
    test_start_ignored();
    test_extremes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
